// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ writeback sources.
// The winning request is registered onto the write port one cycle after its grant.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Freeze,
  input  logic [NUM_REQ-1:0]        ReqValid,
  input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] ReqData,
  output logic [NUM_REQ-1:0]        Grant,
  output logic                      WriteEnable,
  output logic [ADDR_W-1:0]         WriteAddr,
  output logic [DATA_W-1:0]         WriteData,
  output logic [CNT_W-1:0]          ConflictCount
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  r_ptr;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_any;
  logic [PTR_W-1:0]  w_win_idx;
  logic              w_grant_en;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_data;
  logic [PTR_W-1:0]  w_next_ptr;
  logic              w_conflict;

  function automatic logic [3:0] popcount(input logic [NUM_REQ-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i]) begin
        c = c + 4'd1;
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  // Round-robin search starting at r_ptr, wrapping from NUM_REQ-1 back to 0.
  always_comb begin
    logic [PTR_W:0] v_sum;
    w_any     = 1'b0;
    w_win_idx = '0;
    v_sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (v_sum >= (PTR_W+1)'(NUM_REQ)) begin
        v_sum = v_sum - (PTR_W+1)'(NUM_REQ);
      end else begin
        v_sum = v_sum;
      end
      if (!w_any && ReqValid[v_sum[PTR_W-1:0]]) begin
        w_any     = 1'b1;
        w_win_idx = v_sum[PTR_W-1:0];
      end else begin
        w_any     = w_any;
      end
    end
  end

  assign w_grant_en = w_any & ~Freeze & ~rst;
  assign w_win_addr = ReqAddr[w_win_idx*ADDR_W +: ADDR_W];
  assign w_win_data = ReqData[w_win_idx*DATA_W +: DATA_W];
  assign w_next_ptr = (w_win_idx == PTR_W'(NUM_REQ-1)) ? '0 : (w_win_idx + PTR_W'(1));
  assign w_conflict = ~Freeze & (popcount(ReqValid) >= 4'd2);

  // One-hot grant decode of the search winner.
  always_comb begin
    Grant = '0;
    if (w_grant_en) begin
      Grant[w_win_idx] = 1'b1;
    end else begin
      Grant = '0;
    end
  end

  // Write-port registers and priority pointer; x0 targets consume the slot without writing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_ptr  <= '0;
    end else if (w_grant_en) begin
      r_we   <= (w_win_addr != '0);
      r_addr <= w_win_addr;
      r_data <= w_win_data;
      r_ptr  <= w_next_ptr;
    end else begin
      r_we   <= 1'b0;
    end
  end

  // Saturating count of contended, non-frozen cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_conflict && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Reset kills a registered write before the register file can commit it.
  assign WriteEnable   = r_we & ~rst;
  assign WriteAddr     = r_addr;
  assign WriteData     = r_data;
  assign ConflictCount = r_cnt;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed table, corner sequences and
// randomized traffic compared against a behavioural round-robin model.
module tb_regfile_write_arbiter;

  localparam int N  = 2;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            Freeze = 1'b0;
  logic [N-1:0]    ReqValid = '0;
  logic [N*AW-1:0] ReqAddr = '0;
  logic [N*DW-1:0] ReqData = '0;
  logic [N-1:0]    Grant;
  logic            WriteEnable;
  logic [AW-1:0]   WriteAddr;
  logic [DW-1:0]   WriteData;
  logic [CW-1:0]   ConflictCount;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .Freeze(Freeze), .ReqValid(ReqValid), .ReqAddr(ReqAddr),
    .ReqData(ReqData), .Grant(Grant), .WriteEnable(WriteEnable), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .ConflictCount(ConflictCount)
  );

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  int          m_ptr = 0;
  bit          m_we = 1'b0;
  int unsigned m_addr = 0;
  int unsigned m_data = 0;
  int unsigned m_cnt = 0;
  logic [N-1:0] exp_grant;
  logic [N-1:0] dut_grant;

  typedef struct {
    bit          r;
    bit          f;
    logic [1:0]  v;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  eg;
    bit          ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [3:0]  ec;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic cyc(input bit r, input bit f, input logic [N-1:0] v,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int g;
    int idx;
    @(negedge clk);
    rst = r; Freeze = f; ReqValid = v;
    ReqAddr = {a1, a0};
    ReqData = {d1, d0};
    g = -1;
    if (!r && !f) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_grant = (g < 0) ? '0 : (N'(1) << g);
    #1;
    dut_grant = Grant;
    chk("grant", Grant, exp_grant);
    chk("we_before_edge", WriteEnable, m_we && !r);
    @(posedge clk);
    if (r) begin
      m_ptr = 0; m_we = 1'b0; m_addr = 0; m_data = 0; m_cnt = 0;
    end else begin
      if (g >= 0) begin
        m_addr = (g == 0) ? a0 : a1;
        m_data = (g == 0) ? d0 : d1;
        m_we   = (m_addr != 0);
        m_ptr  = (g + 1) % N;
      end else begin
        m_we = 1'b0;
      end
      if (!f && $countones(v) >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
    end
    #1;
    chk("we", WriteEnable, m_we);
    chk("waddr", WriteAddr, m_addr);
    chk("wdata", WriteData, m_data);
    chk("cnt", ConflictCount, m_cnt);
  endtask

  logic [AW-1:0] ha[N];
  logic [DW-1:0] hd[N];
  logic [N-1:0]  hv;
  bit            rr, ff;

  initial begin
    //          r  f  v      a0 a1 d0            d1         eg     we a   d             c
    tbl[0]  = '{1, 0, 2'b00, 0, 0, 32'h0,        32'h0,  2'b00, 0, 0, 32'h0,        4'd0};
    tbl[1]  = '{1, 0, 2'b11, 1, 2, 32'h11,       32'h22, 2'b00, 0, 0, 32'h0,        4'd0};
    tbl[2]  = '{0, 0, 2'b00, 0, 0, 32'h0,        32'h0,  2'b00, 0, 0, 32'h0,        4'd0};
    tbl[3]  = '{0, 0, 2'b01, 5, 0, 32'hDEADBEEF, 32'h0,  2'b01, 1, 5, 32'hDEADBEEF, 4'd0};
    tbl[4]  = '{0, 0, 2'b00, 5, 0, 32'hDEADBEEF, 32'h0,  2'b00, 0, 5, 32'hDEADBEEF, 4'd0};
    tbl[5]  = '{0, 0, 2'b11, 1, 2, 32'h11,       32'h22, 2'b10, 1, 2, 32'h22,       4'd1};
    tbl[6]  = '{0, 0, 2'b11, 1, 2, 32'h11,       32'h22, 2'b01, 1, 1, 32'h11,       4'd2};
    tbl[7]  = '{0, 0, 2'b11, 1, 2, 32'h11,       32'h22, 2'b10, 1, 2, 32'h22,       4'd3};
    tbl[8]  = '{0, 0, 2'b01, 0, 2, 32'h55,       32'h22, 2'b01, 0, 0, 32'h55,       4'd3};
    tbl[9]  = '{0, 1, 2'b11, 1, 2, 32'h11,       32'h22, 2'b00, 0, 0, 32'h55,       4'd3};
    tbl[10] = '{0, 1, 2'b11, 1, 2, 32'h11,       32'h22, 2'b00, 0, 0, 32'h55,       4'd3};
    tbl[11] = '{0, 1, 2'b11, 1, 2, 32'h11,       32'h22, 2'b00, 0, 0, 32'h55,       4'd3};
    tbl[12] = '{0, 0, 2'b11, 1, 2, 32'h11,       32'h22, 2'b10, 1, 2, 32'h22,       4'd4};

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      chk($sformatf("tbl%0d_grant", i), dut_grant, tbl[i].eg);
      chk($sformatf("tbl%0d_we", i), WriteEnable, tbl[i].ewe);
      chk($sformatf("tbl%0d_addr", i), WriteAddr, tbl[i].ea);
      chk($sformatf("tbl%0d_data", i), WriteData, tbl[i].ed);
      chk($sformatf("tbl%0d_cnt", i), ConflictCount, tbl[i].ec);
    end

    // reset arriving while a granted write sits on the port
    cyc(0, 0, 2'b10, 0, 7, 32'h0, 32'h77);
    chk("mid_rst_pre_we", WriteEnable, 1'b1);
    chk("mid_rst_pre_addr", WriteAddr, 5'd7);
    cyc(1, 0, 2'b00, 0, 0, 32'h0, 32'h0);
    chk("mid_rst_we", WriteEnable, 1'b0);
    chk("mid_rst_cnt", ConflictCount, 4'd0);
    cyc(0, 0, 2'b00, 0, 0, 32'h0, 32'h0);
    chk("post_rst_idle_we", WriteEnable, 1'b0);

    // pointer back at 0 after reset, then 20 conflict cycles saturate the counter
    cyc(0, 0, 2'b11, 3, 4, 32'h33, 32'h44);
    chk("ptr_after_rst", dut_grant, 2'b01);
    for (int i = 1; i < 20; i++) cyc(0, 0, 2'b11, 3, 4, 32'h33, 32'h44);
    chk("cnt_saturated", ConflictCount, 4'hF);
    chk("alt_last_addr", WriteAddr, 5'd4);

    // randomized traffic; requesters hold their request until granted
    hv = '0;
    for (int i = 0; i < N; i++) begin ha[i] = '0; hd[i] = '0; end
    exp_grant = '0;
    for (int c = 0; c < 400; c++) begin
      rr = ($urandom_range(0, 39) == 0);
      ff = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        if (!(hv[i] && !exp_grant[i] && $urandom_range(0, 7) != 0)) begin
          hv[i] = 1'($urandom_range(0, 1));
          ha[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          hd[i] = $urandom;
        end
      end
      cyc(rr, ff, hv, ha[0], ha[1], hd[0], hd[1]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
